iqdemod: RTL



---
 rtl/iq_pkg.sv | 19 +
 rtl/iqdemod_if.sv | 25 ++
 rtl/iq_quant.sv | 24 ++
 rtl/iqdemod.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iq_pkg : shared IQ-link constants and state encoding             |
// |          (used by both iqmod and iqdemod)                         |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
package iq_pkg;
    localparam int ADC_W    = 10;
    localparam int SYM_W    = 4;
    localparam int ADC_MID  = 512;
    localparam int SYM_ZERO = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INTEG = 2'd1,
        DUMP  = 2'd2
    } state_t;
endpackage
`default_nettype wire

// File: rtl/iqdemod_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iqdemod_if : ADC sample input and I/Q symbol output bundle        |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
interface iqdemod_if;
    import iq_pkg::*;

    logic [ADC_W-1:0] adcval;
    logic             adc_valid;
    logic [SYM_W-1:0] sym_i;
    logic [SYM_W-1:0] sym_q;
    logic             sym_valid;

    modport master (
        output adcval, adc_valid,
        input  sym_i, sym_q, sym_valid
    );

    modport slave (
        input  adcval, adc_valid,
        output sym_i, sym_q, sym_valid
    );
endinterface
`default_nettype wire

// File: rtl/iq_quant.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iq_quant : accumulator to 4-bit offset-binary symbol code         |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module iq_quant
    import iq_pkg::*;
#(
    parameter int ACC_W = 14,
    parameter int SHIFT = 9
) (
    input  logic signed [ACC_W-1:0] i_acc,
    output logic        [SYM_W-1:0] o_code
);
    // The accumulator range guarantees the shifted value fits in SYM_W
    // signed bits, so taking the field directly equals a floor shift.
    logic [SYM_W-1:0] w_field;
    logic             w_unused;

    assign w_field  = i_acc[SHIFT +: SYM_W];
    assign o_code   = {~w_field[SYM_W-1], w_field[SYM_W-2:0]};
    assign w_unused = &{1'b0, i_acc};
endmodule
`default_nettype wire

// File: rtl/iqdemod.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iqdemod : fs/4 I/Q mixer with integrate-and-dump per symbol       |
// | Rev 1.0 : initial release                                         |
// +------------------------------------------------------------------+
module iqdemod
    import iq_pkg::*;
#(
    parameter int SYM_LEN = 16
) (
    input  logic     clk,
    input  logic     areset_n,
    input  logic     locked,
    input  logic     sync,
    iqdemod_if.slave bus
);
    localparam int c_LOG2_LEN = $clog2(SYM_LEN);
    localparam int c_ACC_W    = ADC_W + c_LOG2_LEN;
    localparam int c_SHIFT    = c_LOG2_LEN + 5;
    localparam logic [c_LOG2_LEN-1:0] c_N_LAST = c_LOG2_LEN'(SYM_LEN - 1);

    state_t                     r_state;
    state_t                     w_next_state;
    logic signed [c_ACC_W-1:0]  r_acc_i;
    logic signed [c_ACC_W-1:0]  r_acc_q;
    logic signed [c_ACC_W-1:0]  w_acc_i_nxt;
    logic signed [c_ACC_W-1:0]  w_acc_q_nxt;
    logic signed [c_ACC_W-1:0]  w_mix;
    logic signed [ADC_W-1:0]    w_s;
    logic [c_LOG2_LEN-1:0]      r_n;
    logic [c_LOG2_LEN-1:0]      w_n_nxt;
    logic [1:0]                 r_p;
    logic [1:0]                 w_p_nxt;
    logic                       w_run;
    logic                       w_accept;
    logic                       w_restart;
    logic                       w_dump_fire;
    logic                       w_last;
    logic [SYM_W-1:0]           w_code_i;
    logic [SYM_W-1:0]           w_code_q;
    logic [SYM_W-1:0]           r_sym_i;
    logic [SYM_W-1:0]           r_sym_q;
    logic                       r_sym_valid;

    // Offset binary to two's complement is just an MSB inversion.
    assign w_s    = {~bus.adcval[ADC_W-1], bus.adcval[ADC_W-2:0]};
    assign w_mix  = {{c_LOG2_LEN{w_s[ADC_W-1]}}, w_s};
    assign w_last = w_accept && (r_n == c_N_LAST);

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) r_state <= IDLE;
        else           r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (locked) w_next_state = INTEG;
            INTEG: begin
                if (!locked)               w_next_state = IDLE;
                else if (!sync && w_last)  w_next_state = DUMP;
            end
            DUMP:    w_next_state = locked ? INTEG : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_run       = locked && ((r_state == INTEG) || (r_state == DUMP));
        w_accept    = w_run && bus.adc_valid;
        w_restart   = sync || (r_state == DUMP);
        w_dump_fire = locked && !sync && (r_state == DUMP);
    end

    // After a full symbol n and p have already wrapped to 0, so DUMP
    // only needs to zero the accumulator base before mixing.
    always_comb begin
        w_acc_i_nxt = w_restart ? '0 : r_acc_i;
        w_acc_q_nxt = w_restart ? '0 : r_acc_q;
        w_n_nxt     = sync ? '0 : r_n;
        w_p_nxt     = sync ? '0 : r_p;
        if (w_accept) begin
            case (w_p_nxt)
                2'd0:    w_acc_i_nxt = w_acc_i_nxt + w_mix;
                2'd1:    w_acc_q_nxt = w_acc_q_nxt + w_mix;
                2'd2:    w_acc_i_nxt = w_acc_i_nxt - w_mix;
                default: w_acc_q_nxt = w_acc_q_nxt - w_mix;
            endcase
            w_n_nxt = w_n_nxt + c_LOG2_LEN'(1);
            w_p_nxt = w_p_nxt + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_n     <= '0;
            r_p     <= '0;
        end else if (!w_run) begin
            r_acc_i <= '0;
            r_acc_q <= '0;
            r_n     <= '0;
            r_p     <= '0;
        end else begin
            r_acc_i <= w_acc_i_nxt;
            r_acc_q <= w_acc_q_nxt;
            r_n     <= w_n_nxt;
            r_p     <= w_p_nxt;
        end
    end

    iq_quant #(.ACC_W(c_ACC_W), .SHIFT(c_SHIFT)) u_quant_i (
        .i_acc  (r_acc_i),
        .o_code (w_code_i)
    );

    iq_quant #(.ACC_W(c_ACC_W), .SHIFT(c_SHIFT)) u_quant_q (
        .i_acc  (r_acc_q),
        .o_code (w_code_q)
    );

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_sym_i     <= SYM_W'(SYM_ZERO);
            r_sym_q     <= SYM_W'(SYM_ZERO);
            r_sym_valid <= 1'b0;
        end else begin
            r_sym_valid <= w_dump_fire;
            if (w_dump_fire) begin
                r_sym_i <= w_code_i;
                r_sym_q <= w_code_q;
            end
        end
    end

    assign bus.sym_i     = r_sym_i;
    assign bus.sym_q     = r_sym_q;
    assign bus.sym_valid = r_sym_valid;
endmodule
`default_nettype wire
